// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between the memory requester and mem_responder
interface mem_responder_if;
    logic        ReqValid;
    logic        ReqWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        ReqReady;
    logic        RespValid;
    logic        RespErr;
    logic [31:0] ReadData;

    modport master (
        output ReqValid, ReqWrite, Address, WriteData,
        input  ReqReady, RespValid, RespErr, ReadData
    );

    modport slave (
        input  ReqValid, ReqWrite, Address, WriteData,
        output ReqReady, RespValid, RespErr, ReadData
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding word RAM responder with fixed read/write latency
module mem_responder #(
    parameter int ADDR_W    = 8,
    parameter int READ_LAT  = 3,
    parameter int WRITE_LAT = 1
) (
    input  logic           Clock,
    input  logic           Reset,
    mem_responder_if.slave bus
);

    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam int DEPTH   = 1 << ADDR_W;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                mem_we;
    logic                req_err;

    logic [31:0]         mem [DEPTH];

    // Anything outside the RAM window or not word-aligned is answered with an error.
    assign req_err = (bus.Address[1:0] != 2'b00) || (bus.Address[31:ADDR_W+2] != '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = rdata_q;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ReqValid) begin
                    wr_d    = bus.ReqWrite;
                    idx_d   = bus.Address[ADDR_W+1:2];
                    wdata_d = bus.WriteData;
                    err_d   = req_err;
                    cnt_d   = bus.ReqWrite ? WR_LOAD : RD_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                    if (err_q) begin
                        rdata_d = 32'd0;
                    end else if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx_q];
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Storage is not cleared by reset; a reset edge also cancels a pending commit.
    always_ff @(posedge Clock) begin
        if (Reset && mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.ReqReady  = (state_q == IDLE) && Reset;
    assign bus.RespValid = resp_valid_q;
    assign bus.RespErr   = resp_err_q;
    assign bus.ReadData  = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

    localparam int RLAT = 3;
    localparam int WLAT = 1;

    logic Clock = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 Clock = ~Clock;

    mem_responder_if a();
    mem_responder_if b();

    mem_responder #(.ADDR_W(8), .READ_LAT(RLAT), .WRITE_LAT(WLAT)) dut_a (
        .Clock (Clock),
        .Reset (rst_a),
        .bus   (a)
    );

    mem_responder #(.ADDR_W(8), .READ_LAT(3), .WRITE_LAT(3)) dut_b (
        .Clock (Clock),
        .Reset (rst_b),
        .bus   (b)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [31:0] model_mem [256];
    logic [31:0] model_rd;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] ad);
        return (ad[1:0] != 2'b00) || (ad[31:10] != 22'd0);
    endfunction

    task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd, input string name);
        int n;
        int lat;
        logic busy_ok;
        @(negedge Clock);
        n = 0;
        while (a.ReqReady !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        chk({name, " ready"}, {31'd0, a.ReqReady}, 32'd1);
        a.ReqValid  = 1'b1;
        a.ReqWrite  = wr;
        a.Address   = addr;
        a.WriteData = wd;
        @(posedge Clock);
        #1;
        a.ReqValid  = 1'($urandom_range(0, 1));
        a.ReqWrite  = 1'($urandom);
        a.Address   = $urandom;
        a.WriteData = $urandom;
        busy_ok = (a.ReqReady === 1'b0);
        lat = 0;
        while (lat < 12) begin
            @(posedge Clock);
            #1;
            lat++;
            if (a.ReqReady !== 1'b0) busy_ok = 1'b0;
            if (a.RespValid === 1'b1) break;
        end
        chk({name, " latency"}, 32'(lat), wr ? 32'(WLAT) : 32'(RLAT));
        chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
        chk({name, " err"}, {31'd0, a.RespErr}, {31'd0, exp_err});
        chk({name, " rdata"}, a.ReadData, exp_rd);
        @(posedge Clock);
        #1;
        a.ReqValid = 1'b0;
        chk({name, " pulse"}, {31'd0, a.RespValid}, 32'd0);
        chk({name, " hold"}, a.ReadData, exp_rd);
        if (!exp_err && wr) model_mem[addr[9:2]] = wd;
        model_rd = exp_rd;
    endtask

    task automatic model_xact(input logic wr, input logic [31:0] ad, input logic [31:0] wd, input string name);
        logic        e;
        logic [31:0] exp;
        e = addr_err(ad);
        if (e)       exp = 32'd0;
        else if (wr) exp = model_rd;
        else         exp = model_mem[ad[9:2]];
        xact(wr, ad, wd, e, exp, name);
    endtask

    initial begin
        logic [31:0] q_addr [$];
        logic [31:0] pa;
        int          last_c;
        int          nresp;
        int          n;
        logic        seen;

        vt[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0000_0000};
        vt[1]  = '{1'b1, 32'h0000_03FC, 32'h2222_2222, 1'b0, 32'h0000_0000};
        vt[2]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vt[3]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[4]  = '{1'b0, 32'h0000_0043, 32'h0,         1'b1, 32'h0000_0000};
        vt[5]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[6]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 1'b1, 32'h0000_0000};
        vt[7]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111};
        vt[8]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h2222_2222};
        vt[9]  = '{1'b1, 32'h0000_0080, 32'hCAFE_F00D, 1'b0, 32'h2222_2222};
        vt[10] = '{1'b0, 32'h0000_0080, 32'h0,         1'b0, 32'hCAFE_F00D};
        vt[11] = '{1'b0, 32'h1000_0040, 32'h0,         1'b1, 32'h0000_0000};
        vt[12] = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[13] = '{1'b1, 32'h0000_0402, 32'h5555_AAAA, 1'b1, 32'h0000_0000};
        vt[14] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111};

        a.ReqValid = 1'b0; a.ReqWrite = 1'b0; a.Address = '0; a.WriteData = '0;
        b.ReqValid = 1'b0; b.ReqWrite = 1'b0; b.Address = '0; b.WriteData = '0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        model_rd = 32'd0;
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;

        repeat (3) @(posedge Clock);
        #1;
        chk("reset ReqReady", {31'd0, a.ReqReady}, 32'd0);
        chk("reset RespValid", {31'd0, a.RespValid}, 32'd0);
        chk("reset RespErr", {31'd0, a.RespErr}, 32'd0);
        chk("reset ReadData", a.ReadData, 32'd0);
        @(negedge Clock);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(posedge Clock);
        #1;
        chk("post-reset ReqReady", {31'd0, a.ReqReady}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            xact(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_err, vt[i].exp_rd, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 256; i++) begin
            model_xact(1'b1, 32'(i * 4), $urandom, "fill");
        end

        // Requester keeps ReqValid high; only IDLE-cycle addresses may be serviced.
        @(negedge Clock);
        a.ReqValid = 1'b1;
        a.ReqWrite = 1'b0;
        last_c = -1;
        nresp = 0;
        for (int c = 0; c < 25; c++) begin
            a.Address = (c % 2 == 1) ? 32'h44 : 32'h40;
            if (a.ReqReady === 1'b1) q_addr.push_back(a.Address);
            @(posedge Clock);
            #1;
            if (a.RespValid === 1'b1) begin
                nresp++;
                if (q_addr.size() == 0) begin
                    chk("stream unexpected resp", 32'd1, 32'd0);
                end else begin
                    pa = q_addr.pop_front();
                    chk("stream rdata", a.ReadData, model_mem[pa[9:2]]);
                    model_rd = model_mem[pa[9:2]];
                end
                if (last_c >= 0) chk("stream interval", 32'(c - last_c), 32'(RLAT + 2));
                last_c = c;
            end
            @(negedge Clock);
        end
        a.ReqValid = 1'b0;
        n = 0;
        while (q_addr.size() != 0 && n < 10) begin
            @(posedge Clock);
            #1;
            if (a.RespValid === 1'b1) begin
                pa = q_addr.pop_front();
                chk("stream drain rdata", a.ReadData, model_mem[pa[9:2]]);
                model_rd = model_mem[pa[9:2]];
            end
            n++;
        end
        chk("stream responses", 32'(nresp), 32'd5);
        chk("stream drained", 32'(q_addr.size()), 32'd0);

        for (int i = 0; i < 120; i++) begin
            logic [31:0] ad;
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)       ad = 32'($urandom_range(0, 15) * 4);
            else if (r == 7) ad = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (r == 8) ad = {22'($urandom_range(1, 4194303)), 10'($urandom)};
            else             ad = 32'($urandom_range(0, 255) * 4);
            model_xact(1'($urandom), ad, $urandom, "rand");
        end

        // Reset must cancel an uncommitted write on the WRITE_LAT=3 instance.
        @(negedge Clock);
        b.ReqValid = 1'b1; b.ReqWrite = 1'b1; b.Address = 32'h80; b.WriteData = 32'h0102_0304;
        @(posedge Clock);
        #1;
        b.ReqValid = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge Clock);
            #1;
            seen = (b.RespValid === 1'b1);
            n++;
        end
        chk("b prewrite ack", {31'd0, seen}, 32'd1);
        @(negedge Clock);
        n = 0;
        while (b.ReqReady !== 1'b1 && n < 10) begin
            @(negedge Clock);
            n++;
        end
        b.ReqValid = 1'b1; b.ReqWrite = 1'b1; b.Address = 32'h80; b.WriteData = 32'hA5A5_A5A5;
        @(posedge Clock);
        #1;
        b.ReqValid = 1'b0;
        @(negedge Clock);
        rst_b = 1'b0;
        @(posedge Clock);
        #1;
        chk("b ReqReady in reset", {31'd0, b.ReqReady}, 32'd0);
        @(negedge Clock);
        rst_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clock);
            #1;
            if (b.RespValid !== 1'b0) seen = 1'b1;
        end
        chk("b no resp after reset", {31'd0, seen}, 32'd0);
        chk("b idle after reset", {31'd0, b.ReqReady}, 32'd1);
        chk("b ReadData after reset", b.ReadData, 32'd0);
        @(negedge Clock);
        b.ReqValid = 1'b1; b.ReqWrite = 1'b0; b.Address = 32'h80;
        @(posedge Clock);
        #1;
        b.ReqValid = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge Clock);
            #1;
            n++;
            seen = (b.RespValid === 1'b1);
        end
        chk("b read latency", 32'(n), 32'd3);
        chk("b read prior value", b.ReadData, 32'h0102_0304);
        chk("b read err", {31'd0, b.RespErr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
